// File: rtl/fetch_pc_reg.sv
// Fetch-stage PC register: Avalon-style instruction fetch, hold while the instruction executes, MIPS delay-slot redirect.
// A jump to address zero halts the core until reset.
module fetch_pc_reg (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] pc_next,
   input  logic        redirect,
   input  logic        stall,
   input  logic        instr_waitrequest,
   input  logic [31:0] instr_readdata,
   output logic [31:0] instr_address,
   output logic        instr_read,
   output logic [31:0] pc,
   output logic [31:0] pc4,
   output logic [31:0] instruction,
   output logic        instr_valid,
   output logic        in_delay_slot,
   output logic        active
);

   localparam logic [31:0] RESET_PC = 32'hBFC0_0000;

   typedef enum logic [1:0] {
      FETCH,
      EXEC,
      HALT
   } state_t;

   state_t      state;
   logic        pending;
   logic [31:0] pending_target;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state          <= FETCH;
         pc             <= RESET_PC;
         pending        <= 1'b0;
         pending_target <= 32'h0;
         instruction    <= 32'h0;
         in_delay_slot  <= 1'b0;
         active         <= 1'b1;
      end else begin
         unique case (state)
            FETCH: begin
               if (!instr_waitrequest) begin
                  instruction <= instr_readdata;
                  state       <= EXEC;
               end
            end
            EXEC: begin
               if (!stall) begin
                  if (pending) begin
                     // the delay slot has retired; take the branch now
                     pc            <= pending_target;
                     pending       <= 1'b0;
                     in_delay_slot <= 1'b0;
                     if (pending_target == 32'h0) begin
                        state  <= HALT;
                        active <= 1'b0;
                     end else begin
                        state <= FETCH;
                     end
                  end else begin
                     pc    <= pc + 32'd4;
                     state <= FETCH;
                     if (redirect) begin
                        pending        <= 1'b1;
                        pending_target <= pc_next;
                        in_delay_slot  <= 1'b1;
                     end
                  end
               end
            end
            HALT: begin
               active <= 1'b0;
            end
            default: begin
               state <= HALT;
            end
         endcase
      end
   end

   assign instr_address = pc;
   assign pc4           = pc + 32'd4;
   assign instr_read    = reset & (state == FETCH);
   assign instr_valid   = reset & (state == EXEC);

endmodule

// File: tb/tb_fetch_pc_reg.sv
// Bench for fetch_pc_reg: directed boot/branch/halt/reset scenarios, then random traffic,
// every cycle compared against a transaction-level model.
module tb_fetch_pc_reg;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [31:0] pc_next = '0;
   logic        redirect = 1'b0;
   logic        stall = 1'b0;
   logic        instr_waitrequest = 1'b0;
   logic [31:0] instr_readdata = '0;
   logic [31:0] instr_address;
   logic        instr_read;
   logic [31:0] pc;
   logic [31:0] pc4;
   logic [31:0] instruction;
   logic        instr_valid;
   logic        in_delay_slot;
   logic        active;

   int errors = 0;
   int checks = 0;

   fetch_pc_reg dut (
      .clk               (clk),
      .reset             (reset),
      .pc_next           (pc_next),
      .redirect          (redirect),
      .stall             (stall),
      .instr_waitrequest (instr_waitrequest),
      .instr_readdata    (instr_readdata),
      .instr_address     (instr_address),
      .instr_read        (instr_read),
      .pc                (pc),
      .pc4               (pc4),
      .instruction       (instruction),
      .instr_valid       (instr_valid),
      .in_delay_slot     (in_delay_slot),
      .active            (active)
   );

   always #5 clk = ~clk;

   // model: where the core is (fetching / holding an instruction / halted)
   logic [31:0] m_pc;
   logic [31:0] m_instr;
   bit          m_holding;
   bit          m_halted;
   bit          m_slot;
   logic [31:0] m_targets[$];

   task automatic model_reset();
      m_pc      = 32'hBFC0_0000;
      m_instr   = 32'h0;
      m_holding = 1'b0;
      m_halted  = 1'b0;
      m_slot    = 1'b0;
      m_targets.delete();
   endtask

   task automatic model_step();
      logic [31:0] t;
      if (m_halted) return;
      if (!m_holding) begin
         if (!instr_waitrequest) begin
            m_instr   = instr_readdata;
            m_holding = 1'b1;
         end
         return;
      end
      if (stall) return;
      m_holding = 1'b0;
      if (m_targets.size() != 0) begin
         t      = m_targets.pop_front();
         m_pc   = t;
         m_slot = 1'b0;
         if (t == 32'h0) m_halted = 1'b1;
      end else begin
         if (redirect) begin
            m_targets.push_back(pc_next);
            m_slot = 1'b1;
         end
         m_pc = m_pc + 32'd4;
      end
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s t=%0t actual=%h required=%h", nm, $time, act, exp);
      end
   endtask

   task automatic compare_all();
      logic e_read;
      logic e_valid;
      e_read  = reset && !m_halted && !m_holding;
      e_valid = reset && m_holding;
      chk("instr_address", instr_address, m_pc);
      chk("pc", pc, m_pc);
      chk("pc4", pc4, m_pc + 32'd4);
      chk("instruction", instruction, m_instr);
      chk("instr_read", {31'b0, instr_read}, {31'b0, e_read});
      chk("instr_valid", {31'b0, instr_valid}, {31'b0, e_valid});
      chk("in_delay_slot", {31'b0, in_delay_slot}, {31'b0, m_slot});
      chk("active", {31'b0, active}, {31'b0, !m_halted});
   endtask

   task automatic tick();
      @(posedge clk);
      if (reset) model_step();
      @(negedge clk);
      #1;
      compare_all();
   endtask

   task automatic set_in(input bit wr, input bit st, input bit rd,
                         input logic [31:0] nx, input logic [31:0] data);
      instr_waitrequest = wr;
      stall             = st;
      redirect          = rd;
      pc_next           = nx;
      instr_readdata    = data;
   endtask

   task automatic do_reset();
      reset = 1'b0;
      #1;
      model_reset();
      compare_all();
      tick();
      reset = 1'b1;
      #1;
      compare_all();
   endtask

   // fetch with no wait then execute one instruction with given redirect
   task automatic run_instr(input logic [31:0] data, input bit rd, input logic [31:0] nx);
      set_in(1'b0, 1'b0, 1'b0, 32'h0, data);
      tick();
      set_in(1'b0, 1'b0, rd, nx, 32'h0);
      tick();
   endtask

   initial begin
      @(negedge clk);
      #1;
      model_reset();
      compare_all();
      chk("lit_reset_read", {31'b0, instr_read}, 32'h0);
      chk("lit_reset_pc", pc, 32'hBFC0_0000);
      reset = 1'b1;
      #1;

      // boot
      chk("lit_boot_addr", instr_address, 32'hBFC0_0000);
      chk("lit_boot_read", {31'b0, instr_read}, 32'h1);
      set_in(1'b0, 1'b0, 1'b0, 32'h0, 32'h1111_0000);
      tick();
      chk("lit_boot_valid", {31'b0, instr_valid}, 32'h1);
      chk("lit_boot_instr", instruction, 32'h1111_0000);
      tick();
      chk("lit_boot_next", instr_address, 32'hBFC0_0004);

      // waitrequest for 3 cycles
      do_reset();
      set_in(1'b1, 1'b0, 1'b0, 32'h0, 32'hDEAD_BEEF);
      repeat (3) begin
         tick();
         chk("lit_wait_addr", instr_address, 32'hBFC0_0000);
         chk("lit_wait_valid", {31'b0, instr_valid}, 32'h0);
      end
      set_in(1'b0, 1'b0, 1'b0, 32'h0, 32'h2222_0000);
      tick();
      chk("lit_wait_instr", instruction, 32'h2222_0000);
      tick();

      // taken branch at BFC00008 with delay slot, then stalled redirect
      do_reset();
      run_instr(32'h1, 1'b0, 32'h0);
      run_instr(32'h2, 1'b0, 32'h0);
      run_instr(32'h3, 1'b1, 32'hBFC0_0020);
      chk("lit_slot_addr", instr_address, 32'hBFC0_000C);
      chk("lit_slot_flag", {31'b0, in_delay_slot}, 32'h1);
      run_instr(32'h4, 1'b0, 32'h0);
      chk("lit_target_addr", instr_address, 32'hBFC0_0020);
      chk("lit_target_flag", {31'b0, in_delay_slot}, 32'h0);
      set_in(1'b0, 1'b0, 1'b0, 32'h0, 32'h5);
      tick();
      set_in(1'b0, 1'b1, 1'b1, 32'h1234_5678, 32'h0);
      repeat (2) begin
         tick();
         chk("lit_stall_pc", pc, 32'hBFC0_0020);
         chk("lit_stall_instr", instruction, 32'h5);
      end
      set_in(1'b0, 1'b0, 1'b1, 32'hBFC0_0041, 32'h0);
      tick();
      chk("lit_stall_slot", pc, 32'hBFC0_0024);
      run_instr(32'h6, 1'b1, 32'hBFC0_0080);
      chk("lit_first_target_wins", pc, 32'hBFC0_0041);

      // wrap of pc4, then reset during a waitrequest with a pending target
      run_instr(32'h7, 1'b1, 32'hFFFF_FFFC);
      run_instr(32'h8, 1'b0, 32'h0);
      chk("lit_wrap_pc", pc, 32'hFFFF_FFFC);
      chk("lit_wrap_pc4", pc4, 32'h0);
      run_instr(32'h9, 1'b1, 32'hBFC0_0100);
      set_in(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
      tick();
      tick();
      do_reset();
      chk("lit_rst_pc", pc, 32'hBFC0_0000);
      run_instr(32'hA, 1'b0, 32'h0);
      chk("lit_rst_seq1", instr_address, 32'hBFC0_0004);
      run_instr(32'hB, 1'b0, 32'h0);
      chk("lit_rst_seq2", instr_address, 32'hBFC0_0008);
      chk("lit_rst_noslot", {31'b0, in_delay_slot}, 32'h0);

      // jr to zero at BFC00010
      do_reset();
      repeat (4) run_instr(32'hC, 1'b0, 32'h0);
      run_instr(32'hD, 1'b1, 32'h0);
      chk("lit_jr0_slot", instr_address, 32'hBFC0_0014);
      run_instr(32'hE, 1'b0, 32'h0);
      repeat (5) begin
         chk("lit_halt_active", {31'b0, active}, 32'h0);
         chk("lit_halt_read", {31'b0, instr_read}, 32'h0);
         chk("lit_halt_pc", pc, 32'h0);
         tick();
      end

      // random traffic
      do_reset();
      for (int i = 0; i < 4000; i++) begin
         logic [31:0] tgt;
         tgt = ($urandom_range(0, 24) == 0) ? 32'h0 : $urandom();
         set_in($urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
                $urandom_range(0, 4) == 0, tgt, $urandom());
         if ($urandom_range(0, 199) == 0 || (m_halted && $urandom_range(0, 7) == 0))
            do_reset();
         else
            tick();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/fetch_pc_reg.md
FETCH_PC_REG -- requirements
Module: fetch_pc_reg

Interface
REQ-001 SHALL have ports: clk  in  1  sole clock; all state updates on rising edge.
REQ-002 SHALL have ports: reset  in  1  asynchronous, active-low; 0 forces reset state immediately.
REQ-003 SHALL have ports: pc_next  in  32  next-PC value from the pc_update stage (its pc_out).
REQ-004 SHALL have ports: redirect  in  1  current instruction is a taken branch/jump; pc_next holds the target.
REQ-005 SHALL have ports: stall  in  1  downstream cannot accept PC advance this cycle.
REQ-006 SHALL have ports: instr_waitrequest  in  1  instruction memory not ready; instr_readdata invalid.
REQ-007 SHALL have ports: instr_readdata  in  32  instruction word from instruction memory.
REQ-008 SHALL have ports: instr_address  out  32  byte address presented to instruction memory.
REQ-009 SHALL have ports: instr_read  out  1  instruction memory read request.
REQ-010 SHALL have ports: pc  out  32  address of the instruction currently held.
REQ-011 SHALL have ports: pc4  out  32  pc + 4, fed to pc_update.
REQ-012 SHALL have ports: instruction  out  32  latched instruction word.
REQ-013 SHALL have ports: instr_valid  out  1  instruction/pc valid for execute this cycle.
REQ-014 SHALL have ports: in_delay_slot  out  1  held instruction is a branch delay slot.
REQ-015 SHALL have ports: active  out  1  CPU running; 0 once halted.

Function
REQ-016 SHALL implement a three-state FSM: FETCH, EXEC, HALT.
REQ-017 In FETCH: instr_read=1, instr_address=pc, instr_valid=0.
REQ-018 FETCH SHALL remain in FETCH while instr_waitrequest=1, holding instr_address stable.
REQ-019 FETCH with instr_waitrequest=0 SHALL latch instr_readdata into instruction and enter EXEC at the next edge; fetch latency is 1 cycle plus wait cycles.
REQ-020 In EXEC: instr_read=0, instr_valid=1; pc, pc4, and instruction held constant.
REQ-021 EXEC with stall=1 SHALL remain in EXEC, with redirect ignored until the stall releases.
REQ-022 EXEC with stall=0 SHALL advance: if pending=1, pc<=pending_target, pending<=0, in_delay_slot<=0; else pc<=pc+4.
REQ-023 EXEC with stall=0, redirect=1 and pending=0 SHALL set pending<=1, pending_target<=pc_next, in_delay_slot<=1 (the next fetched instruction is the delay slot).
REQ-024 A redirect asserted while pending=1 (branch in delay slot) SHALL be ignored; the earlier target wins.
REQ-025 When an EXEC advance would load pc with 32'h00000000 from pending_target, SHALL enter HALT instead of FETCH.
REQ-026 Any other EXEC advance SHALL return to FETCH.
REQ-027 HALT SHALL be terminal until reset: active=0, instr_read=0, instr_valid=0, pc=0.
REQ-028 pc4 SHALL equal pc+4 modulo 2^32 combinationally; 32'hFFFFFFFC+4 wraps to 0.
REQ-029 pc_next[1:0]!=0 SHALL be stored unmodified; alignment faults are not this block's concern.

Reset
REQ-030 reset=0 SHALL asynchronously force state=FETCH, pc=32'hBFC00000, pending=0, pending_target=0, instruction=0, in_delay_slot=0, active=1.
REQ-031 Under reset: instr_valid=0, instr_read=0; instr_read SHALL rise only after reset deasserts.
REQ-032 Reset asserted during FETCH-with-waitrequest or during EXEC SHALL discard the outstanding fetch and the pending target.

Verification
REQ-033 Boot: release reset, waitrequest=0 -> instr_address=BFC00000 with instr_read=1; instr_valid=1 one cycle later; then fetch at BFC00004.
REQ-034 Waitrequest: hold waitrequest=1 for 3 cycles at BFC00000 -> address stable 4 cycles; instruction latched on the fourth; instr_valid follows.
REQ-035 Taken branch at BFC00008 with pc_next=BFC00020 -> next fetch BFC0000C with in_delay_slot=1; following fetch BFC00020 with in_delay_slot=0.
REQ-036 jr to 0 (redirect=1, pc_next=0) at BFC00010 -> delay slot BFC00014 executes; then active=0, instr_read stays 0 indefinitely.
REQ-037 Stall=1 for 2 cycles in EXEC with redirect=1 -> pc and instruction unchanged; target captured only on the cycle stall=0.
REQ-038 Reset pulsed mid-waitrequest with pending target BFC00100 -> pc=BFC00000; pending cleared; post-reset fetch sequence starts BFC00000, BFC00004.
